// File: rtl/register_file_mp.sv
// Multi-ported register file with write-to-read bypass and busy scoreboard; r0 reads as zero.
// Reads are combinational (bypass same-cycle); writes/claims land at the edge; claim_stall refuses a claim on a busy register.
module register_file_mp #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 32,
   parameter int NREAD  = 2,
   parameter int NWRITE = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREAD*AWIDTH-1:0]  raddr,
   output logic [NREAD*DWIDTH-1:0]  rdata,
   output logic [NREAD-1:0]         rbusy,
   input  logic [NWRITE-1:0]        we,
   input  logic [NWRITE*AWIDTH-1:0] waddr,
   input  logic [NWRITE*DWIDTH-1:0] wdata,
   input  logic                     claim_en,
   input  logic [AWIDTH-1:0]        claim_addr,
   output logic                     claim_stall
);

   localparam int DEPTH = 2**AWIDTH;

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  clr_vec;
   logic [DEPTH-1:0]  set_vec;

   always_comb begin
      clr_vec = '0;
      for (int j = 0; j < NWRITE; j++) begin
         if (we[j] && waddr[j*AWIDTH +: AWIDTH] != '0)
            clr_vec[waddr[j*AWIDTH +: AWIDTH]] = 1'b1;
      end
   end

   // A writeback retiring the claimed register this cycle frees it for the new claim.
   assign claim_stall = claim_en && (claim_addr != '0) && busy[claim_addr] && !clr_vec[claim_addr];

   always_comb begin
      set_vec = '0;
      if (claim_en && claim_addr != '0 && !claim_stall)
         set_vec[claim_addr] = 1'b1;
   end

   // Ascending port order: the highest-index writer to an address wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
         for (int a = 0; a < DEPTH; a++)
            mem[a] <= '0;
      end else begin
         busy <= (busy & ~clr_vec) | set_vec;
         for (int j = 0; j < NWRITE; j++) begin
            if (we[j] && waddr[j*AWIDTH +: AWIDTH] != '0)
               mem[waddr[j*AWIDTH +: AWIDTH]] <= wdata[j*DWIDTH +: DWIDTH];
         end
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AWIDTH-1:0] ra;
      logic [DWIDTH-1:0] rd;
      logic              hit;

      assign ra = raddr[i*AWIDTH +: AWIDTH];

      always_comb begin
         rd  = mem[ra];
         hit = 1'b0;
         if (BYPASS != 0) begin
            for (int j = 0; j < NWRITE; j++) begin
               if (we[j] && waddr[j*AWIDTH +: AWIDTH] == ra) begin
                  hit = 1'b1;
                  rd  = wdata[j*DWIDTH +: DWIDTH];
               end
            end
         end
         if (ra == '0) begin
            rd  = '0;
            hit = 1'b0;
         end
      end

      assign rdata[i*DWIDTH +: DWIDTH] = rd;
      assign rbusy[i] = busy[ra] & ~hit;
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: bypassing and non-bypassing instances share stimulus and are
// checked every cycle against an array-based reference model, plus directed literal checks.
module tb_register_file_mp;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 4;
   localparam int NW = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NR*AW-1:0] raddr = '0;
   logic [NW-1:0]    we = '0;
   logic [NW*AW-1:0] waddr = '0;
   logic [NW*DW-1:0] wdata = '0;
   logic             claim_en = 1'b0;
   logic [AW-1:0]    claim_addr = '0;

   logic [NR*DW-1:0] rdata_b, rdata_n;
   logic [NR-1:0]    rbusy_b, rbusy_n;
   logic             stall_b, stall_n;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] m_mem  [32];
   bit            m_busy [32];

   always #5 clk = ~clk;

   register_file_mp #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR), .NWRITE(NW), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
      .we(we), .waddr(waddr), .wdata(wdata),
      .claim_en(claim_en), .claim_addr(claim_addr), .claim_stall(stall_b));

   register_file_mp #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR), .NWRITE(NW), .BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
      .we(we), .waddr(waddr), .wdata(wdata),
      .claim_en(claim_en), .claim_addr(claim_addr), .claim_stall(stall_n));

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] wa(input int j);
      return waddr[j*AW +: AW];
   endfunction

   function automatic logic [AW-1:0] ra(input int i);
      return raddr[i*AW +: AW];
   endfunction

   function automatic bit written(input logic [AW-1:0] a);
      for (int j = 0; j < NW; j++)
         if (we[j] && wa(j) == a && a != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input bit bp, input int i);
      logic [AW-1:0] a = ra(i);
      if (a == 0) return '0;
      if (bp)
         for (int j = NW-1; j >= 0; j--)
            if (we[j] && wa(j) == a) return wdata[j*DW +: DW];
      return m_mem[a];
   endfunction

   function automatic bit exp_rb(input bit bp, input int i);
      logic [AW-1:0] a = ra(i);
      if (a == 0) return 1'b0;
      if (bp && written(a)) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic bit exp_stall();
      return claim_en && claim_addr != 0 && m_busy[claim_addr] && !written(claim_addr);
   endfunction

   initial begin
      for (int a = 0; a < 32; a++) begin
         m_mem[a]  = '0;
         m_busy[a] = 1'b0;
      end
   end

   // Reference model: state as plain arrays, updated at each rising edge.
   always @(posedge clk) begin
      bit st;
      if (rst) begin
         for (int a = 0; a < 32; a++) begin
            m_mem[a]  = '0;
            m_busy[a] = 1'b0;
         end
      end else begin
         st = exp_stall();
         for (int j = 0; j < NW; j++)
            if (we[j] && wa(j) != 0) begin
               m_mem[wa(j)]  = wdata[j*DW +: DW];
               m_busy[wa(j)] = 1'b0;
            end
         if (claim_en && claim_addr != 0 && !st)
            m_busy[claim_addr] = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         for (int i = 0; i < NR; i++) begin
            chk($sformatf("byp rdata%0d", i), rdata_b[i*DW +: DW], exp_rd(1'b1, i));
            chk($sformatf("byp rbusy%0d", i), {31'b0, rbusy_b[i]}, {31'b0, exp_rb(1'b1, i)});
            chk($sformatf("nobyp rdata%0d", i), rdata_n[i*DW +: DW], exp_rd(1'b0, i));
            chk($sformatf("nobyp rbusy%0d", i), {31'b0, rbusy_n[i]}, {31'b0, exp_rb(1'b0, i)});
         end
         chk("byp claim_stall", {31'b0, stall_b}, {31'b0, exp_stall()});
         chk("nobyp claim_stall", {31'b0, stall_n}, {31'b0, exp_stall()});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0;
      we = '0;
      claim_en = 1'b0;
   endtask

   task automatic set_w(input int j, input int a, input logic [DW-1:0] d);
      we[j] = 1'b1;
      waddr[j*AW +: AW] = AW'(a);
      wdata[j*DW +: DW] = d;
   endtask

   function automatic int pick();
      return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
   endfunction

   task automatic randomize_inputs(input bit allow_rst);
      rst = allow_rst && ($urandom_range(0, 399) == 0);
      we = NW'($urandom_range(0, 7));
      for (int j = 0; j < NW; j++) begin
         waddr[j*AW +: AW] = AW'(pick());
         wdata[j*DW +: DW] = $urandom;
      end
      for (int i = 0; i < NR; i++)
         raddr[i*AW +: AW] = AW'(pick());
      claim_en = ($urandom_range(0, 1) == 1);
      claim_addr = AW'(pick());
   endtask

   initial begin
      rst = 1'b1;
      tick();
      idle();
      chk_en = 1'b1;

      repeat (50) begin
         randomize_inputs(1'b0);
         tick();
      end

      // Reset after random traffic, then read every address.
      idle();
      rst = 1'b1;
      tick();
      idle();
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NR; i++) raddr[i*AW +: AW] = AW'(4*k + i);
         @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            chk("reset rdata", rdata_b[i*DW +: DW] | rdata_n[i*DW +: DW], 32'h0);
            chk("reset rbusy", {30'b0, rbusy_b[i], rbusy_n[i]}, 32'h0);
         end
         tick();
      end

      // Two ports hit r5: the higher index wins.
      set_w(0, 5, 32'h11);
      set_w(1, 5, 32'h22);
      raddr[0 +: AW] = 5'd5;
      @(negedge clk);
      chk("conflict bypass same cycle", rdata_b[0 +: DW], 32'h22);
      chk("conflict nobypass same cycle", rdata_n[0 +: DW], 32'h0);
      tick();
      idle();
      @(negedge clk);
      chk("conflict bypass next", rdata_b[0 +: DW], 32'h22);
      chk("conflict nobypass next", rdata_n[0 +: DW], 32'h22);
      tick();

      // Register 0 ignores writes and claims.
      for (int j = 0; j < NW; j++) set_w(j, 0, 32'hDEADBEEF);
      claim_en = 1'b1;
      claim_addr = '0;
      raddr[0 +: AW] = '0;
      @(negedge clk);
      chk("r0 rdata bypass", rdata_b[0 +: DW], 32'h0);
      chk("r0 claim_stall", {31'b0, stall_b}, 32'h0);
      tick();
      idle();
      @(negedge clk);
      chk("r0 rdata after", rdata_n[0 +: DW], 32'h0);
      chk("r0 rbusy after", {30'b0, rbusy_b[0], rbusy_n[0]}, 32'h0);
      tick();

      // Bypass r7.
      set_w(0, 7, 32'h5);
      tick();
      idle();
      set_w(0, 7, 32'hA5);
      raddr[1*AW +: AW] = 5'd7;
      @(negedge clk);
      chk("bypass r7 same cycle", rdata_b[1*DW +: DW], 32'hA5);
      chk("nobypass r7 old value", rdata_n[1*DW +: DW], 32'h5);
      tick();
      idle();
      @(negedge clk);
      chk("nobypass r7 next cycle", rdata_n[1*DW +: DW], 32'hA5);
      tick();

      // Scoreboard on r3.
      claim_en = 1'b1;
      claim_addr = 5'd3;
      raddr[0 +: AW] = 5'd3;
      @(negedge clk);
      chk("claim r3 accepted", {31'b0, stall_b}, 32'h0);
      chk("r3 not busy yet", {31'b0, rbusy_b[0]}, 32'h0);
      tick();
      @(negedge clk);
      chk("r3 busy after claim", {30'b0, rbusy_b[0], rbusy_n[0]}, 32'h3);
      chk("second claim stalls", {30'b0, stall_b, stall_n}, 32'h3);
      tick();
      set_w(2, 3, 32'h77);
      @(negedge clk);
      chk("claim with writeback no stall", {30'b0, stall_b, stall_n}, 32'h0);
      chk("r3 rbusy during writeback", {30'b0, rbusy_b[0], rbusy_n[0]}, 32'h1);
      tick();
      idle();
      @(negedge clk);
      chk("r3 stays busy (set wins)", {30'b0, rbusy_b[0], rbusy_n[0]}, 32'h3);
      tick();
      set_w(0, 3, 32'h99);
      @(negedge clk);
      chk("r3 later writeback bypass", rdata_b[0 +: DW], 32'h99);
      tick();
      idle();
      @(negedge clk);
      chk("r3 cleared", {30'b0, rbusy_b[0], rbusy_n[0]}, 32'h0);
      tick();

      // Randomized sweep with occasional mid-operation reset.
      repeat (10000) begin
         randomize_inputs(1'b1);
         tick();
      end

      idle();
      tick();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
